// File: rtl/time_display_mux.sv
// time_display_mux: binary hh/mm/ss to BCD, 6-digit multiplexed common-anode 7-segment driver
// with a lap/freeze function. The snapshot only changes at frame boundaries, so every frame
// shows one coherent time.
// Optional feature: define BLANK_LEADING_ZERO_EN to blank the hours tens digit when hour < 10.
module time_display_mux #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [3:0] hour,
    input  logic       lap,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frozen
);

    typedef enum logic {StRun, StHold} state_e;

    localparam logic [15:0] PrescMax = 16'(REFRESH_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] presc_q;
    logic [2:0]  idx_q;
    logic [15:0] snap_q;  // {hour, min, sec}
    logic        tick, frame_end, snap_load;

    logic [7:0]  sec_bcd, min_bcd, hour_bcd;
    logic [3:0]  digit;
    logic [5:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    // Binary 0..63 to {tens, ones} by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        for (int i = 0; i < 6; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    // Active-low {g,f,e,d,c,b,a} patterns.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tick      = (presc_q == PrescMax);
    assign frame_end = tick && (idx_q == 3'd5);
    assign frozen    = (state_q == StHold);

    // Prescaler and digit index advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 16'd0;
            idx_q   <= 3'd0;
        end else if (tick) begin
            presc_q <= 16'd0;
            idx_q   <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    // Freeze next state; snapshot load uses next state so a lap on the boundary takes effect.
    always_comb begin
        state_d = state_q;
        if (lap) begin
            state_d = (state_q == StRun) ? StHold : StRun;
        end
        snap_load = frame_end && (state_d == StRun);
    end

    // Freeze state and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            snap_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (snap_load) begin
                snap_q <= {hour, min, sec};
            end
        end
    end

    assign sec_bcd  = to_bcd(snap_q[5:0]);
    assign min_bcd  = to_bcd(snap_q[11:6]);
    assign hour_bcd = to_bcd({2'b00, snap_q[15:12]});

    // Digit select and decode for the current index.
    always_comb begin
        digit = 4'd0;
        an_d  = 6'b111111;
        dp_d  = 1'b1;
        case (idx_q)
            3'd0: digit = sec_bcd[3:0];
            3'd1: digit = sec_bcd[7:4];
            3'd2: digit = min_bcd[3:0];
            3'd3: digit = min_bcd[7:4];
            3'd4: digit = hour_bcd[3:0];
            3'd5: digit = hour_bcd[7:4];
            default: digit = 4'd0;
        endcase
        if (idx_q <= 3'd5) begin
            an_d[idx_q] = 1'b0;
        end
        dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
        seg_d = seg_of(digit);
`ifdef BLANK_LEADING_ZERO_EN
        if ((idx_q == 3'd5) && (snap_q[15:12] < 4'd10)) begin
            an_d  = 6'b111111;
            seg_d = 7'b1111111;
        end
`endif
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_time_display_mux.sv
// Bench for time_display_mux: directed scenarios plus random stimulus, checked every cycle
// against a cycle-count based model of the display.
module tb_time_display_mux;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec, min;
    logic [3:0] hour;
    logic       lap;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frozen;

    int n_vec = 0;
    int n_bad = 0;

    time_display_mux #(.REFRESH_DIV(D)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hour(hour), .lap(lap),
        .an(an), .seg(seg), .dp(dp), .frozen(frozen)
    );

    always #5 clk = ~clk;

    // Model state: edges since reset release, freeze flag, displayed snapshot.
    int          m_edges;
    logic        m_frozen;
    logic [15:0] m_snap;
    logic        have_exp;
    logic [5:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_frozen;

    function automatic logic [6:0] pat(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic int digit_val(input int idx, input logic [15:0] s);
        int h, m, sc;
        h  = int'(s[15:12]);
        m  = int'(s[11:6]);
        sc = int'(s[5:0]);
        case (idx)
            0: return sc % 10;
            1: return sc / 10;
            2: return m % 10;
            3: return m / 10;
            4: return h % 10;
            default: return h / 10;
        endcase
    endfunction

    function automatic logic blank(input int idx, input logic [15:0] s);
`ifdef BLANK_LEADING_ZERO_EN
        return (idx == 5) && (s[15:12] < 4'd10);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [5:0] f_an(input int idx, input logic [15:0] s);
        if (blank(idx, s)) return 6'b111111;
        return ~(6'b000001 << idx);
    endfunction

    function automatic logic [6:0] f_seg(input int idx, input logic [15:0] s);
        if (blank(idx, s)) return 7'b1111111;
        return pat(digit_val(idx, s));
    endfunction

    // Outputs after edge n show digit ((n-1)/D)%6 of the snapshot held before that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges  <= 0;
            m_frozen <= 1'b0;
            m_snap   <= 16'd0;
            have_exp <= 1'b0;
        end else begin
            m_edges    <= m_edges + 1;
            m_frozen   <= m_frozen ^ lap;
            have_exp   <= 1'b1;
            exp_frozen <= m_frozen ^ lap;
            exp_an     <= f_an((m_edges / D) % 6, m_snap);
            exp_seg    <= f_seg((m_edges / D) % 6, m_snap);
            exp_dp     <= !((((m_edges / D) % 6) == 2) || (((m_edges / D) % 6) == 4));
            if (((m_edges + 1) % (6 * D)) == 0 && !(m_frozen ^ lap)) begin
                m_snap <= {hour, min, sec};
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_an", int'(an), 6'b111111);
            check("rst_seg", int'(seg), 7'b1111111);
            check("rst_dp", int'(dp), 1);
            check("rst_frozen", int'(frozen), 0);
        end else if (have_exp) begin
            check("an", int'(an), int'(exp_an));
            check("seg", int'(seg), int'(exp_seg));
            check("dp", int'(dp), int'(exp_dp));
            check("frozen", int'(frozen), int'(exp_frozen));
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        lap  = 1'b0;
        sec  = 6'd0;
        min  = 6'd0;
        hour = 4'd0;
        clocks(3);
        rst  = 1'b0;
        hour = 4'd12;
        min  = 6'd34;
        sec  = 6'd56;
        clocks(1);                                   // k=1
        check("lit_first_an", int'(an), 6'b111110);
        check("lit_first_seg", int'(seg), 7'b1000000);
        clocks(24);                                  // k=25: frame 2, idx 0
        check("lit_1234_s0", int'(seg), 7'b0000010);
        check("lit_1234_an0", int'(an), 6'b111110);
        clocks(8);                                   // k=33: idx 2
        check("lit_1234_s2", int'(seg), 7'b0011001);
        check("lit_1234_dp2", int'(dp), 0);
        check("lit_1234_an2", int'(an), 6'b111011);
        sec = 6'd57;                                 // mid-frame change
        clocks(14);                                  // k=47
        hour = 4'd0;
        min  = 6'd0;
        sec  = 6'd5;
        clocks(24);                                  // k=71
        sec = 6'd9;
        lap = 1'b1;                                  // lands on boundary edge 72
        clocks(1);
        lap = 1'b0;
        clocks(1);                                   // k=73
        check("lit_hold_s0", int'(seg), 7'b0010010);
        check("lit_hold_frz", int'(frozen), 1);
        clocks(22);                                  // k=95
        lap = 1'b1;                                  // leaving HOLD on boundary 96
        clocks(1);
        lap = 1'b0;
        clocks(1);                                   // k=97
        check("lit_run_s0", int'(seg), 7'b0010000);
        check("lit_run_frz", int'(frozen), 0);
        hour = 4'd15;
        min  = 6'd0;
        sec  = 6'd63;
        clocks(24);                                  // k=121
        check("lit_63_ones", int'(seg), 7'b0110000);
        clocks(4);                                   // k=125
        check("lit_63_tens", int'(seg), 7'b0000010);
        clocks(16);                                  // k=141: idx 5
        check("lit_15_tens", int'(seg), 7'b1111001);
        check("lit_15_an5", int'(an), 6'b011111);
        hour = 4'd7;
        clocks(24);                                  // k=165: idx 5, hour 7
`ifdef BLANK_LEADING_ZERO_EN
        check("lit_7_tens", int'(seg), 7'b1111111);
        check("lit_7_an5", int'(an), 6'b111111);
`else
        check("lit_7_tens", int'(seg), 7'b1000000);
        check("lit_7_an5", int'(an), 6'b011111);
`endif
        // Back-to-back lap pulses.
        lap = 1'b1;
        clocks(2);
        lap = 1'b0;
        clocks(1);
        check("lit_b2b_frz", int'(frozen), 0);
        // Random phase.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) sec = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) min = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) hour = 4'($urandom_range(0, 15));
            lap = ($urandom_range(0, 9) == 0);
            clocks(1);
        end
        lap = 1'b0;
        clocks(1);
        // Enter HOLD then reset asynchronously mid-frame.
        lap = !m_frozen;
        clocks(1);
        lap = 1'b0;
        clocks(5);
        check("lit_pre_rst_frz", int'(frozen), 1);
        #2 rst = 1'b1;
        #1;
        check("lit_async_an", int'(an), 6'b111111);
        check("lit_async_seg", int'(seg), 7'b1111111);
        check("lit_async_dp", int'(dp), 1);
        check("lit_async_frz", int'(frozen), 0);
        clocks(2);
        rst = 1'b0;
        clocks(4);
        check("lit_rel_an_a", int'(an), 6'b111110);
        clocks(1);
        check("lit_rel_an_b", int'(an), 6'b111101);
        clocks(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
